// File: rtl/dram_seq_pkg.sv
// Shared types and defaults for the MSX main-RAM strobe sequencer.
package dram_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ROW      = 3'd1,
    ST_COL      = 3'd2,
    ST_CAS      = 3'd3,
    ST_RFSH_CBR = 3'd4,
    ST_RFSH     = 3'd5,
    ST_PRE      = 3'd6
  } state_t;

  localparam int DEF_T_RAS_MUX = 1;
  localparam int DEF_T_MUX_CAS = 1;
  localparam int DEF_T_PRE     = 2;

  localparam int RFSH_RAS_ONLY = 0;
  localparam int RFSH_CBR      = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_seq_timer.sv
// Loadable down-counter: load on state entry, done while the count sits at 1.
module dram_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Count down toward 1 and park there until the next load.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count > W'(1))
      count <= count - W'(1);
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/dram_ras_cas_seq.sv
// Registered DRAM /RAS,/CAS,MUX,/WE sequencer for Z80 CPU and refresh cycles.
module dram_ras_cas_seq
  import dram_seq_pkg::*;
#(
  parameter int BANKS        = 2,
  parameter int T_RAS_MUX    = DEF_T_RAS_MUX,
  parameter int T_MUX_CAS    = DEF_T_MUX_CAS,
  parameter int T_PRE        = DEF_T_PRE,
  parameter int REFRESH_MODE = RFSH_RAS_ONLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nmreq,
  input  logic             nrfsh,
  input  logic             nwr,
  input  logic [BANKS-1:0] nsltsl,
  output logic [BANKS-1:0] nras,
  output logic             ncas,
  output logic             mux,
  output logic             nwe,
  output logic             busy,
  output logic [7:0]       rfsh_count
);

  localparam int TMAX = max3(T_RAS_MUX, T_MUX_CAS, T_PRE);
  localparam int CW   = $clog2(TMAX + 1);
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam state_t RFSH_ENTRY = (REFRESH_MODE == RFSH_CBR) ? ST_RFSH_CBR : ST_RFSH;

  state_t          state, state_nxt;
  logic [BW-1:0]   bank_q, bank_sel, bank_nxt;
  logic            any_sel, req_rfsh, req_cpu, enter, rfsh_inc;
  logic            tmr_load, tmr_done;
  logic [CW-1:0]   tmr_val;
  logic [BANKS-1:0] nras_bank, nras_nxt;
  logic            ncas_nxt, mux_nxt, nwe_nxt;

  assign req_rfsh = !nmreq && !nrfsh;
  assign req_cpu  = !nmreq && nrfsh && any_sel;

  // Lowest-index active slot select wins the bank.
  always_comb begin
    bank_sel = '0;
    any_sel  = 1'b0;
    for (int i = BANKS - 1; i >= 0; i--) begin
      if (!nsltsl[i]) begin
        bank_sel = BW'(i);
        any_sel  = 1'b1;
      end
    end
  end

  // Next-state decode; nmreq high in any active state ends or aborts the cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_rfsh)     state_nxt = RFSH_ENTRY;
        else if (req_cpu) state_nxt = ST_ROW;
      end
      ST_ROW: begin
        if (nmreq)         state_nxt = ST_PRE;
        else if (tmr_done) state_nxt = ST_COL;
      end
      ST_COL: begin
        if (nmreq)         state_nxt = ST_PRE;
        else if (tmr_done) state_nxt = ST_CAS;
      end
      ST_CAS:      if (nmreq) state_nxt = ST_PRE;
      ST_RFSH_CBR: state_nxt = nmreq ? ST_PRE : ST_RFSH;
      ST_RFSH:     if (nmreq) state_nxt = ST_PRE;
      ST_PRE: begin
        if (tmr_done) begin
          if (req_rfsh)     state_nxt = RFSH_ENTRY;
          else if (req_cpu) state_nxt = ST_ROW;
          else              state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timer load, bank latch and refresh-count strobes on state entry.
  always_comb begin
    enter    = (state_nxt != state);
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_nxt)
      ST_ROW: begin tmr_load = enter; tmr_val = CW'(T_RAS_MUX); end
      ST_COL: begin tmr_load = enter; tmr_val = CW'(T_MUX_CAS); end
      ST_PRE: begin tmr_load = enter; tmr_val = CW'(T_PRE);     end
      default: ;
    endcase
    bank_nxt = (enter && state_nxt == ST_ROW) ? bank_sel : bank_q;
    rfsh_inc = enter && (state == ST_IDLE || state == ST_PRE) &&
               (state_nxt == ST_RFSH || state_nxt == ST_RFSH_CBR);
  end

  // Strobe values for the state being entered; they are registered below.
  always_comb begin
    for (int i = 0; i < BANKS; i++)
      nras_bank[i] = !(BW'(i) == bank_nxt);
    nras_nxt = '1;
    ncas_nxt = 1'b1;
    mux_nxt  = 1'b0;
    nwe_nxt  = 1'b1;
    case (state_nxt)
      ST_ROW: nras_nxt = nras_bank;
      ST_COL: begin
        nras_nxt = nras_bank;
        mux_nxt  = 1'b1;
      end
      ST_CAS: begin
        nras_nxt = nras_bank;
        mux_nxt  = 1'b1;
        ncas_nxt = 1'b0;
        nwe_nxt  = (state == ST_CAS) ? nwe : nwr;
      end
      ST_RFSH_CBR: ncas_nxt = 1'b0;
      ST_RFSH: begin
        nras_nxt = '0;
        ncas_nxt = (REFRESH_MODE == RFSH_CBR) ? 1'b0 : 1'b1;
      end
      default: ;
    endcase
  end

  dram_seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      nras       <= '1;
      ncas       <= 1'b1;
      mux        <= 1'b0;
      nwe        <= 1'b1;
      busy       <= 1'b0;
      rfsh_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      nras       <= nras_nxt;
      ncas       <= ncas_nxt;
      mux        <= mux_nxt;
      nwe        <= nwe_nxt;
      busy       <= (state_nxt != ST_IDLE);
      if (rfsh_inc)
        rfsh_count <= rfsh_count + 8'd1;
    end
  end

  // Bank index is datapath: only meaningful after it is latched on ROW entry.
  always_ff @(posedge clk) begin
    bank_q <= bank_nxt;
  end

endmodule

// File: tb/tb_dram_ras_cas_seq.sv
// Directed bench for dram_ras_cas_seq: RAS-only instance (dut0) and CBR instance (dut1).
module tb_dram_ras_cas_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, nmreq, nrfsh, nwr;
  logic [1:0] nsltsl;

  logic [1:0] nras0, nras1;
  logic       ncas0, mux0, nwe0, busy0;
  logic       ncas1, mux1, nwe1, busy1;
  logic [7:0] cnt0, cnt1;

  dram_ras_cas_seq #(.BANKS(2), .T_RAS_MUX(1), .T_MUX_CAS(1), .T_PRE(2), .REFRESH_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .nmreq(nmreq), .nrfsh(nrfsh), .nwr(nwr), .nsltsl(nsltsl),
    .nras(nras0), .ncas(ncas0), .mux(mux0), .nwe(nwe0), .busy(busy0), .rfsh_count(cnt0)
  );

  dram_ras_cas_seq #(.BANKS(2), .T_RAS_MUX(1), .T_MUX_CAS(1), .T_PRE(2), .REFRESH_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .nmreq(nmreq), .nrfsh(nrfsh), .nwr(nwr), .nsltsl(nsltsl),
    .nras(nras1), .ncas(ncas1), .mux(mux1), .nwe(nwe1), .busy(busy1), .rfsh_count(cnt1)
  );

  typedef struct {
    string      tag;
    int         dut;
    logic [1:0] nras;
    logic       ncas;
    logic       mux;
    logic       nwe;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expd(input string tag, input int d, input logic [1:0] nr,
                      input logic cs, input logic mx, input logic we, input logic by);
    exp_t e;
    e.tag = tag; e.dut = d; e.nras = nr; e.ncas = cs; e.mux = mx;
    e.nwe = we; e.busy = by; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic expb(input string tag, input logic [1:0] nr,
                      input logic cs, input logic mx, input logic we, input logic by);
    expd(tag, 0, nr, cs, mx, we, by);
    expd({tag, "_cbr"}, 1, nr, cs, mx, we, by);
  endtask

  // One clock edge, then compare every expectation queued for it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        chk({e.tag, ".nras"}, {6'd0, nras0}, {6'd0, e.nras});
        chk({e.tag, ".ncas"}, {7'd0, ncas0}, {7'd0, e.ncas});
        chk({e.tag, ".mux"},  {7'd0, mux0},  {7'd0, e.mux});
        chk({e.tag, ".nwe"},  {7'd0, nwe0},  {7'd0, e.nwe});
        chk({e.tag, ".busy"}, {7'd0, busy0}, {7'd0, e.busy});
        chk({e.tag, ".cnt"},  cnt0,          e.cnt);
      end else begin
        chk({e.tag, ".nras"}, {6'd0, nras1}, {6'd0, e.nras});
        chk({e.tag, ".ncas"}, {7'd0, ncas1}, {7'd0, e.ncas});
        chk({e.tag, ".mux"},  {7'd0, mux1},  {7'd0, e.mux});
        chk({e.tag, ".nwe"},  {7'd0, nwe1},  {7'd0, e.nwe});
        chk({e.tag, ".busy"}, {7'd0, busy1}, {7'd0, e.busy});
        chk({e.tag, ".cnt"},  cnt1,          e.cnt);
      end
    end
  endtask

  initial begin
    // Reset held for two edges with a request pending on the bus
    rst = 1'b1; nmreq = 1'b0; nrfsh = 1'b1; nwr = 1'b1; nsltsl = 2'b00;
    tick();
    expb("reset", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0; nmreq = 1'b1; nsltsl = 2'b11;
    expb("idle", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // Read bank 0
    nmreq = 1'b0; nsltsl = 2'b10; nwr = 1'b1;
    expb("rd_e1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expb("rd_e2", 2'b10, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    expb("rd_e3", 2'b10, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    expb("rd_hold", 2'b10, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    nmreq = 1'b1;
    expb("rd_end", 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expb("rd_pre", 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expb("rd_idle", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();

    // Write bank 1; late nwr / nsltsl changes must be ignored
    nmreq = 1'b0; nsltsl = 2'b01; nwr = 1'b0;
    expd("wr_e1", 0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("wr_e2", 0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    expd("wr_e3", 0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    nwr = 1'b1; nsltsl = 2'b10;
    expd("wr_hold", 0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    nmreq = 1'b1; nsltsl = 2'b01;
    expd("wr_end", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    // New request arrives during precharge and is honoured at expiry
    nmreq = 1'b0;
    expd("b2b_pre", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("b2b_row", 0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("b2b_col", 0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    nmreq = 1'b1;
    expd("col_abort", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("col_pre", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("col_idle", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();

    // Abort in ROW: /CAS never falls
    nmreq = 1'b0; nsltsl = 2'b10;
    expd("ab_row", 0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    nmreq = 1'b1;
    expd("ab_pre", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("ab_pre2", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expd("ab_idle", 0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();

    // Refresh: RAS-only on dut0, CAS-before-RAS on dut1
    nmreq = 1'b0; nrfsh = 1'b0; nsltsl = 2'b11; exp_cnt = 8'd1;
    expd("rfsh_e1", 0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    expd("cbr_e1",  1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expd("rfsh_e2", 0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    expd("cbr_e2",  1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    nmreq = 1'b1; nrfsh = 1'b1;
    expb("rfsh_end", 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expb("rfsh_pre", 2'b11, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    expb("rfsh_idle", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();

    // Refresh has priority over active slot selects
    nmreq = 1'b0; nrfsh = 1'b0; nsltsl = 2'b00; exp_cnt = 8'd2;
    expd("prio", 0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    expd("prio_cbr", 1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    nmreq = 1'b1; nrfsh = 1'b1; nsltsl = 2'b11;
    tick(); tick(); tick();

    // Run the refresh counter up to 255, then wrap
    for (int k = 3; k <= 255; k++) begin
      nmreq = 1'b0; nrfsh = 1'b0; exp_cnt = 8'(k);
      tick();
      nmreq = 1'b1; nrfsh = 1'b1;
      tick(); tick(); tick();
    end
    expb("cnt255", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    nmreq = 1'b0; nrfsh = 1'b0; exp_cnt = 8'd0;
    expd("wrap", 0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    expd("wrap_cbr", 1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    nmreq = 1'b1; nrfsh = 1'b1;
    tick(); tick(); tick();

    // Reset asserted while in CAS
    nmreq = 1'b0; nsltsl = 2'b10; nwr = 1'b0;
    tick(); tick();
    expb("rc_cas", 2'b10, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    rst = 1'b1; exp_cnt = 8'd0;
    expb("rc_rst", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    rst = 1'b0; nmreq = 1'b1; nsltsl = 2'b11; nwr = 1'b1;
    expb("rc_idle", 2'b11, 1'b1, 1'b0, 1'b1, 1'b0); tick();

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
